// File: rtl/uart_pkg.sv
// Frame layout constants shared by the UART capture stage and the receive buffer.
package uart_pkg;

    localparam int FRAME_BITS_DEF = 10;
    localparam int START_POS      = FRAME_BITS_DEF - 1;
    localparam int STOP_POS       = 0;
    localparam int DATA_MSB       = 8;
    localparam int DATA_LSB       = 1;
    localparam int DATA_BITS      = DATA_MSB - DATA_LSB + 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop & ~empty & ~rst;
    assign do_push = push & (~full | do_pop) & ~rst;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_frame_buffer.sv
// Checks UART framing, queues good payload bytes and counts framing errors and drops.
module uart_frame_buffer
    import uart_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_valid,
    input  logic [FRAME_BITS-1:0]   frame,
    input  logic                    pop,
    output logic                    rd_valid,
    output logic [7:0]              rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    input  logic                    clr_stats,
    output logic [CNT_WIDTH-1:0]    ferr_count,
    output logic [CNT_WIDTH-1:0]    ovf_count
);

    localparam int SP = FRAME_BITS - 1;

    logic                 good;
    logic                 push;
    logic                 ferr_evt;
    logic                 ovf_evt;
    logic                 empty;
    logic [DATA_BITS-1:0] head;

    assign good     = ~frame[SP] & frame[STOP_POS];
    assign push     = frame_valid & good;
    assign ferr_evt = frame_valid & ~good;
    assign ovf_evt  = push & full & ~pop;

    sync_fifo #(
        .DATA_WIDTH (DATA_BITS),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (frame[DATA_MSB:DATA_LSB]),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign rd_valid = ~empty;
    assign rd_data  = rd_valid ? head : '0;

    // Clear wins over a coincident event; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            ferr_count <= '0;
            ovf_count  <= '0;
        end else begin
            if (ferr_evt && !(&ferr_count))
                ferr_count <= ferr_count + 1'b1;
            if (ovf_evt && !(&ovf_count))
                ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Directed self-checking bench for uart_frame_buffer.
module tb_uart_frame_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_valid = 1'b0;
    logic [9:0] frame = '0;
    logic       pop = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       clr_stats = 1'b0;
    logic [7:0] ferr_count;
    logic [7:0] ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_frame_buffer #(
        .FRAME_BITS (10),
        .DEPTH      (16),
        .CNT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame       (frame),
        .pop         (pop),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .clr_stats   (clr_stats),
        .ferr_count  (ferr_count),
        .ovf_count   (ovf_count)
    );

    function automatic logic [9:0] good_f(input logic [7:0] b);
        return {1'b0, b, 1'b1};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        pop         = 1'b0;
        clr_stats   = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        frame_valid = 1'b1;
        frame       = good_f(b);
        cyc();
    endtask

    initial begin
        // reset, with a frame and pop offered during reset
        rst = 1'b1;
        cyc();
        rst = 1'b1; frame_valid = 1'b1; frame = good_f(8'h11); pop = 1'b1;
        cyc();
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ferr", 32'(ferr_count), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);

        // single byte
        frame_valid = 1'b1; frame = 10'b0_1010_0101_1;
        cyc();
        chk("a5_valid", 32'(rd_valid), 32'd1);
        chk("a5_data", 32'(rd_data), 32'hA5);
        chk("a5_count", 32'(count), 32'd1);
        pop = 1'b1;
        cyc();
        chk("a5_pop_valid", 32'(rd_valid), 32'd0);
        chk("a5_pop_data", 32'(rd_data), 32'd0);
        chk("a5_pop_count", 32'(count), 32'd0);
        pop = 1'b1;
        cyc();
        chk("empty_pop_count", 32'(count), 32'd0);

        // framing errors
        frame_valid = 1'b1; frame = 10'b1_0011_1100_1;
        cyc();
        frame_valid = 1'b1; frame = 10'b0_0011_1100_0;
        cyc();
        chk("ferr_two", 32'(ferr_count), 32'd2);
        chk("ferr_count0", 32'(count), 32'd0);
        chk("ferr_valid", 32'(rd_valid), 32'd0);

        // fill and overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_head", 32'(rd_data), 32'h00);
        push_byte(8'h77);
        chk("ovf_one", 32'(ovf_count), 32'd1);
        chk("ovf_count16", 32'(count), 32'd16);

        // full with simultaneous push and pop
        clr_stats = 1'b1;
        cyc();
        chk("clr_ovf", 32'(ovf_count), 32'd0);
        chk("clr_ferr", 32'(ferr_count), 32'd0);
        frame_valid = 1'b1; frame = good_f(8'h55); pop = 1'b1;
        cyc();
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovf", 32'(ovf_count), 32'd0);
        chk("pp_full", 32'(full), 32'd1);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
            pop = 1'b1;
            cyc();
        end
        chk("drain_last", 32'(rd_data), 32'h55);
        chk("drain_last_cnt", 32'(count), 32'd1);
        pop = 1'b1;
        cyc();
        chk("drain_empty", 32'(rd_valid), 32'd0);
        chk("drain_full0", 32'(full), 32'd0);

        // saturation and clear
        for (int i = 0; i < 300; i++) begin
            frame_valid = 1'b1; frame = 10'b1_0000_0000_0;
            cyc();
        end
        chk("ferr_sat", 32'(ferr_count), 32'd255);
        chk("sat_count", 32'(count), 32'd0);
        clr_stats = 1'b1; frame_valid = 1'b1; frame = 10'b1_0000_0000_1;
        cyc();
        chk("clr_coincident", 32'(ferr_count), 32'd0);

        // reset mid-stream
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        frame_valid = 1'b1; frame = 10'b0_0000_0000_0;
        cyc();
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_ferr", 32'(ferr_count), 32'd1);
        rst = 1'b1; frame_valid = 1'b1; frame = good_f(8'h99);
        cyc();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'd0);
        chk("mid_rst_ferr", 32'(ferr_count), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_count), 32'd0);
        push_byte(8'h3C);
        chk("post_rst_data", 32'(rd_data), 32'h3C);
        chk("post_rst_count", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
